// File: rtl/frame_extremum_tracker.sv
// Per-frame running max/min tracker with first-occurrence indices, built on
// two cmp_n magnitude comparators; one result word is handed off per frame.

module cmp_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_go,
  output logic         o_eo,
  output logic         o_lo
);
  assign o_go = (i_a > i_b);
  assign o_eo = (i_a == i_b);
  assign o_lo = (i_a < i_b);
endmodule

module frame_extremum_tracker #(
  parameter int N         = 8,
  parameter int FRAME_LEN = 16,
  parameter int IW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_max,
  output logic [N-1:0]  out_min,
  output logic [IW-1:0] out_max_idx,
  output logic [IW-1:0] out_min_idx,
  output logic [IW:0]   out_cnt
);

  localparam logic [IW:0] LP_LEN = (IW + 1)'(FRAME_LEN);

  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_in_ready_nxt;
  logic          w_out_valid_nxt;
  logic [N-1:0]  r_max;
  logic [N-1:0]  r_min;
  logic [IW-1:0] r_max_idx;
  logic [IW-1:0] r_min_idx;
  logic [IW:0]   r_cnt;
  logic [N-1:0]  r_out_max;
  logic [N-1:0]  r_out_min;
  logic [IW-1:0] r_out_max_idx;
  logic [IW-1:0] r_out_min_idx;
  logic [IW:0]   r_out_cnt;
  logic [N-1:0]  w_max_upd;
  logic [N-1:0]  w_min_upd;
  logic [IW-1:0] w_max_idx_upd;
  logic [IW-1:0] w_min_idx_upd;
  logic [IW:0]   w_cnt_inc;
  logic          w_accept;
  logic          w_out_fire;
  logic          w_first;
  logic          w_frame_end;
  logic          w_go_max, w_eo_max, w_lo_max;
  logic          w_go_min, w_eo_min, w_lo_min;
  logic          w_take_max;
  logic          w_take_min;

  cmp_n #(.N(N)) u_cmp_max (
    .i_a  (in_data),
    .i_b  (r_max),
    .o_go (w_go_max),
    .o_eo (w_eo_max),
    .o_lo (w_lo_max)
  );

  cmp_n #(.N(N)) u_cmp_min (
    .i_a  (in_data),
    .i_b  (r_min),
    .o_go (w_go_min),
    .o_eo (w_eo_min),
    .o_lo (w_lo_min)
  );

  assign w_accept    = in_valid & r_in_ready;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_first     = (r_cnt == {(IW + 1){1'b0}});
  assign w_cnt_inc   = r_cnt + {{IW{1'b0}}, 1'b1};
  assign w_frame_end = w_accept & ((w_cnt_inc == LP_LEN) | in_last);
  // Only a clean one-hot comparator verdict may move an extremum; ties never do.
  assign w_take_max  = w_go_max & ~w_eo_max & ~w_lo_max;
  assign w_take_min  = w_lo_min & ~w_eo_min & ~w_go_min;

  // Candidate extrema after folding in the current beat.
  always_comb begin
    w_max_upd     = r_max;
    w_min_upd     = r_min;
    w_max_idx_upd = r_max_idx;
    w_min_idx_upd = r_min_idx;
    if (w_first) begin
      w_max_upd     = in_data;
      w_min_upd     = in_data;
      w_max_idx_upd = {IW{1'b0}};
      w_min_idx_upd = {IW{1'b0}};
    end else begin
      if (w_take_max) begin
        w_max_upd     = in_data;
        w_max_idx_upd = r_cnt[IW-1:0];
      end else begin
        w_max_upd     = r_max;
        w_max_idx_upd = r_max_idx;
      end
      if (w_take_min) begin
        w_min_upd     = in_data;
        w_min_idx_upd = r_cnt[IW-1:0];
      end else begin
        w_min_upd     = r_min;
        w_min_idx_upd = r_min_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_frame_end) w_state_nxt = ST_HOLD;
        else             w_state_nxt = ST_ACCUM;
      end
      ST_HOLD: begin
        if (w_out_fire) w_state_nxt = ST_ACCUM;
        else            w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // FSM outputs, computed for the upcoming state and registered below.
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (w_state_nxt)
      ST_ACCUM: begin
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
      ST_HOLD: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b1;
      end
      default: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Handshake flags, running extrema and the held result word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_max         <= {N{1'b0}};
      r_min         <= {N{1'b0}};
      r_max_idx     <= {IW{1'b0}};
      r_min_idx     <= {IW{1'b0}};
      r_cnt         <= {(IW + 1){1'b0}};
      r_out_max     <= {N{1'b0}};
      r_out_min     <= {N{1'b0}};
      r_out_max_idx <= {IW{1'b0}};
      r_out_min_idx <= {IW{1'b0}};
      r_out_cnt     <= {(IW + 1){1'b0}};
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_accept) begin
        r_max     <= w_max_upd;
        r_min     <= w_min_upd;
        r_max_idx <= w_max_idx_upd;
        r_min_idx <= w_min_idx_upd;
        r_cnt     <= w_cnt_inc;
      end else if (w_out_fire) begin
        r_cnt     <= {(IW + 1){1'b0}};
      end else begin
        r_cnt     <= r_cnt;
      end
      if (w_frame_end) begin
        r_out_max     <= w_max_upd;
        r_out_min     <= w_min_upd;
        r_out_max_idx <= w_max_idx_upd;
        r_out_min_idx <= w_min_idx_upd;
        r_out_cnt     <= w_cnt_inc;
      end else begin
        r_out_max     <= r_out_max;
        r_out_min     <= r_out_min;
        r_out_max_idx <= r_out_max_idx;
        r_out_min_idx <= r_out_min_idx;
        r_out_cnt     <= r_out_cnt;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_max     = r_out_max;
  assign out_min     = r_out_min;
  assign out_max_idx = r_out_max_idx;
  assign out_min_idx = r_out_min_idx;
  assign out_cnt     = r_out_cnt;

endmodule

// File: tb/tb_frame_extremum_tracker.sv
// Scoreboard bench for frame_extremum_tracker: a reference model pushes the
// expected result word per frame; each scenario task pops and compares it.

module tb_frame_extremum_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_max;
  logic [7:0] out_min;
  logic [3:0] out_max_idx;
  logic [3:0] out_min_idx;
  logic [4:0] out_cnt;

  typedef struct packed {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [3:0] mxi;
    logic [3:0] mni;
    logic [4:0] cnt;
  } res_t;

  res_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         beats = 0;
  int         results = 0;
  logic [7:0] fb[16];

  frame_extremum_tracker #(.N(8), .FRAME_LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_min    (out_min),
    .out_max_idx(out_max_idx),
    .out_min_idx(out_min_idx),
    .out_cnt    (out_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) beats <= beats + 1;
    if (!rst && out_valid && out_ready) results <= results + 1;
  end

  function automatic res_t observed();
    return {out_max, out_min, out_max_idx, out_min_idx, out_cnt};
  endfunction

  // Drive fb[0..n-1]; optionally random idle gaps; push model result when push=1.
  task automatic send_frame(input int n, input bit last_flag, input bit gaps, input bit push);
    res_t e;
    int   w;
    e.mx = fb[0]; e.mn = fb[0]; e.mxi = 4'd0; e.mni = 4'd0; e.cnt = 5'(n);
    for (int i = 1; i < n; i++) begin
      if (fb[i] > e.mx) begin e.mx = fb[i]; e.mxi = 4'(i); end
      if (fb[i] < e.mn) begin e.mn = fb[i]; e.mni = 4'(i); end
    end
    if (push) sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1; in_data = fb[i]; in_last = last_flag && (i == n - 1);
      w = 0;
      while (!in_ready && w < 30) begin @(posedge clk); #1; w++; end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL beat_accept: in_ready stayed %b, required 1 (beat %0d)", in_ready, i);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int w = 0;
    while (!out_valid && w < 60) begin @(posedge clk); #1; w++; end
    ok = out_valid;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, observed()} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {in_ready, out_valid, observed()});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] s[16] = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd7, 8'd5, 8'd2,
                          8'd8, 8'd6, 8'd1, 8'd4, 8'd3, 8'd7, 8'd2, 8'd8};
    res_t e;
    int   t0;
    for (int i = 0; i < 16; i++) fb[i] = s[i];
    t0 = $time;
    send_frame(16, 1'b0, 1'b0, 1'b1);
    checks++;
    if (($time - t0) != 160) begin
      errors++; $display("FAIL full_throughput: took %0d ns, required 160", $time - t0);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_latency: valid=%b ready=%b, required 1/0", out_valid, in_ready);
    end
    e = sb.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++; $display("FAIL full_result: got %h, required %h", observed(), e);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_release: valid=%b ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_early_terminate();
    res_t e;
    bit   ok;
    fb[0] = 8'd200; fb[1] = 8'd50; fb[2] = 8'd200;
    send_frame(3, 1'b1, 1'b0, 1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || observed() !== e || e !== {8'd200, 8'd50, 4'd0, 4'd1, 5'd3}) begin
      errors++; $display("FAIL early_result: valid=%b got %h, required %h", ok, observed(), e);
    end
    handshake();
  endtask

  task automatic test_single();
    res_t e;
    bit   ok;
    fb[0] = 8'hFF;
    send_frame(1, 1'b1, 1'b0, 1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || observed() !== e) begin
      errors++; $display("FAIL single_result: valid=%b got %h, required %h", ok, observed(), e);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    res_t e;
    bit   ok;
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom_range(1, 254));
    fb[3] = 8'hFF; fb[9] = 8'h00;
    send_frame(16, 1'b1, 1'b0, 1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== e) begin
        errors++;
        $display("FAIL bp_stall c%0d: valid=%b ready=%b got %h, required 1/0 %h",
                 c, out_valid, in_ready, observed(), e);
      end
      @(posedge clk); #1;
    end
    handshake();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b, required 1", in_ready);
    end
    fb[0] = 8'h42; fb[1] = 8'h42;
    send_frame(2, 1'b1, 1'b0, 1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || observed() !== e) begin
      errors++; $display("FAIL bp_next_frame: got %h, required %h", observed(), e);
    end
    handshake();
  endtask

  task automatic test_gaps();
    res_t e;
    int   b0;
    for (int i = 0; i < 16; i++) fb[i] = 8'h80;
    b0 = beats;
    send_frame(16, 1'b0, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (beats - b0 != 16 || out_valid !== 1'b1 || observed() !== e) begin
      errors++;
      $display("FAIL gaps_result: beats=%0d valid=%b got %h, required 16/1 %h",
               beats - b0, out_valid, observed(), e);
    end
    handshake();
  endtask

  task automatic test_reset_mid_frame();
    res_t e;
    bit   ok;
    int   r0;
    for (int i = 0; i < 7; i++) fb[i] = 8'($urandom_range(0, 255));
    send_frame(7, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, observed()} !== 31'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h, required 0", {in_ready, out_valid, observed()});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    r0 = results;
    for (int i = 0; i < 16; i++) fb[i] = 8'd5;
    send_frame(16, 1'b0, 1'b0, 1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || observed() !== e) begin
      errors++; $display("FAIL midrst_result: got %h, required %h", observed(), e);
    end
    handshake();
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if (results - r0 != 1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_count: results=%0d valid=%b, required 1/0", results - r0, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_early_terminate();
    test_single();
    test_backpressure();
    test_gaps();
    test_reset_mid_frame();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
